// File: rtl/regfile_bp_if.sv
// Register file access bus.
//   Read ports : R_Addr_A/B in, R_Data_A/B + Busy_A/B out (combinational)
//   Write port : Write_Reg, W_Addr, W_Data, W_Byte_En
//   Scoreboard : Set_Busy, Busy_Addr
//   Bulk clear : Clear_Req in, Clear_Busy out
// The master modport is the datapath side (decode / writeback / hazard unit);
// the slave modport is the register file itself.
interface regfile_bp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   R_Addr_A;
  logic [ADDR_W-1:0]   R_Addr_B;
  logic [DATA_W-1:0]   R_Data_A;
  logic [DATA_W-1:0]   R_Data_B;
  logic                Write_Reg;
  logic [ADDR_W-1:0]   W_Addr;
  logic [DATA_W-1:0]   W_Data;
  logic [DATA_W/8-1:0] W_Byte_En;
  logic                Set_Busy;
  logic [ADDR_W-1:0]   Busy_Addr;
  logic                Busy_A;
  logic                Busy_B;
  logic                Clear_Req;
  logic                Clear_Busy;

  modport master (
    output R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, W_Byte_En,
           Set_Busy, Busy_Addr, Clear_Req,
    input  R_Data_A, R_Data_B, Busy_A, Busy_B, Clear_Busy
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, W_Byte_En,
           Set_Busy, Busy_Addr, Clear_Req,
    output R_Data_A, R_Data_B, Busy_A, Busy_B, Clear_Busy
  );
endinterface

// File: rtl/regfile_bp.sv
// Parametrised 2-read / 1-write register file with byte-lane write enables,
// optional hardwired zero entry, optional write-to-read bypass, a per-entry
// busy scoreboard for the hazard unit and a sequential bulk-clear engine.
// Ports:
//   CLK         clock, all state changes on posedge
//   Reset_n     asynchronous active-low reset
//   rf          regfile_bp_if.slave bus (read/write/scoreboard/clear)
//   dbg_state_o current clear-FSM state (0 = IDLE, 1 = CLEAR)
// Handshake: there is no valid/ready pair. Write_Reg and Set_Busy are
// single-cycle qualifiers sampled on every posedge; while Clear_Busy is high
// they, and Clear_Req, are dropped rather than held off or queued.
module regfile_bp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          CLK,
  input  logic          Reset_n,
  regfile_bp_if.slave   rf,
  output logic          dbg_state_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                clear_busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;

  logic                idle;
  logic                write_hit;
  logic                set_hit;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;
  logic                fwd_clr_a;
  logic                fwd_clr_b;

  assign idle      = (state_q == S_IDLE);
  assign write_hit = rf.Write_Reg && idle && !((ZERO_REG != 0) && (rf.W_Addr == '0));
  assign set_hit   = rf.Set_Busy && idle && !((ZERO_REG != 0) && (rf.Busy_Addr == '0));

  // Byte-lane merge of the write data onto the current entry contents; used
  // both for the array update and for the same-cycle bypass path.
  always_comb begin
    wr_merged = mem_q[rf.W_Addr];
    for (int i = 0; i < NB; i++) begin
      if (rf.W_Byte_En[i]) wr_merged[8*i +: 8] = rf.W_Data[8*i +: 8];
    end
  end

  // Read ports: zero register overrides everything, then bypass, then array.
  always_comb begin
    rd_a = mem_q[rf.R_Addr_A];
    if ((BYPASS != 0) && write_hit && (rf.W_Addr == rf.R_Addr_A)) rd_a = wr_merged;
    if ((ZERO_REG != 0) && (rf.R_Addr_A == '0)) rd_a = '0;
  end

  always_comb begin
    rd_b = mem_q[rf.R_Addr_B];
    if ((BYPASS != 0) && write_hit && (rf.W_Addr == rf.R_Addr_B)) rd_b = wr_merged;
    if ((ZERO_REG != 0) && (rf.R_Addr_B == '0)) rd_b = '0;
  end

  // A write landing this cycle already resolves the hazard, unless a new
  // producer is claiming the same entry on the same edge.
  assign fwd_clr_a = (BYPASS != 0) && write_hit && (rf.W_Addr == rf.R_Addr_A) &&
                     !(rf.Set_Busy && (rf.Busy_Addr == rf.W_Addr));
  assign fwd_clr_b = (BYPASS != 0) && write_hit && (rf.W_Addr == rf.R_Addr_B) &&
                     !(rf.Set_Busy && (rf.Busy_Addr == rf.W_Addr));

  assign rf.R_Data_A   = rd_a;
  assign rf.R_Data_B   = rd_b;
  assign rf.Busy_A     = busy_q[rf.R_Addr_A] && !fwd_clr_a;
  assign rf.Busy_B     = busy_q[rf.R_Addr_B] && !fwd_clr_b;
  assign rf.Clear_Busy = clear_busy_q;
  assign dbg_state_o   = (state_q == S_CLEAR);

  // Scoreboard next state: set is applied after clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (state_q == S_CLEAR) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      if (write_hit) busy_d[rf.W_Addr]    = 1'b0;
      if (set_hit)   busy_d[rf.Busy_Addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (write_hit) begin
      mem_q[rf.W_Addr] <= wr_merged;
    end
  end

  // Clear FSM: one entry per cycle, DEPTH cycles total, Clear_Busy registered.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rf.Clear_Req) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            clear_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_bp.sv
module tb_regfile_bp;
  logic CLK;
  logic Reset_n;
  logic dbg_byp;
  logic dbg_nobyp;

  int vectors;
  int miscompares;

  regfile_bp_if #(.DATA_W(32), .ADDR_W(5)) bus  ();
  regfile_bp_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  regfile_bp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .rf(bus.slave), .dbg_state_o(dbg_byp)
  );

  regfile_bp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .CLK(CLK), .Reset_n(Reset_n), .rf(bus0.slave), .dbg_state_o(dbg_nobyp)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Write_Reg = 1'b0; bus.W_Addr = '0; bus.W_Data = '0; bus.W_Byte_En = '0;
    bus.Set_Busy = 1'b0; bus.Busy_Addr = '0; bus.Clear_Req = 1'b0;
    bus0.Write_Reg = 1'b0; bus0.W_Addr = '0; bus0.W_Data = '0; bus0.W_Byte_En = '0;
    bus0.Set_Busy = 1'b0; bus0.Busy_Addr = '0; bus0.Clear_Req = 1'b0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.Write_Reg = 1'b1; bus.W_Addr = a; bus.W_Data = d; bus.W_Byte_En = be;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    Reset_n = 1'b0;
    idle_inputs();
    bus.R_Addr_A = 5'd5; bus.R_Addr_B = 5'd31;
    bus0.R_Addr_A = 5'd7; bus0.R_Addr_B = 5'd7;
    tick(); tick();

    // Reset state
    chk("rst_data_a", bus.R_Data_A, 32'h0);
    chk("rst_data_b", bus.R_Data_B, 32'h0);
    chk("rst_busy_a", {31'b0, bus.Busy_A}, 32'h0);
    chk("rst_clear_busy", {31'b0, bus.Clear_Busy}, 32'h0);
    #2 Reset_n = 1'b1;
    tick();

    // Byte-lane write
    drive_write(5'd5, 32'h11223344, 4'hF);
    tick();
    idle_inputs();
    #1 chk("full_write_r5", bus.R_Data_A, 32'h11223344);
    drive_write(5'd5, 32'hAABBCCDD, 4'b0101);
    bus.R_Addr_B = 5'd5;
    #1 chk("byte_merge_bypass_a", bus.R_Data_A, 32'h11BB33DD);
    chk("byte_merge_bypass_b", bus.R_Data_B, 32'h11BB33DD);
    tick();
    idle_inputs();
    #1 chk("byte_merge_r5", bus.R_Data_A, 32'h11BB33DD);
    drive_write(5'd5, 32'hFFFFFFFF, 4'h0);
    #1 chk("zero_be_bypass", bus.R_Data_A, 32'h11BB33DD);
    tick();
    idle_inputs();

    // Bypass vs no-bypass
    bus.R_Addr_A = 5'd7;
    drive_write(5'd7, 32'hDEADBEEF, 4'hF);
    bus0.Write_Reg = 1'b1; bus0.W_Addr = 5'd7; bus0.W_Data = 32'hDEADBEEF; bus0.W_Byte_En = 4'hF;
    #1 chk("bypass_same_cycle", bus.R_Data_A, 32'hDEADBEEF);
    chk("nobypass_old_value", bus0.R_Data_A, 32'h0);
    tick();
    idle_inputs();
    #1 chk("nobypass_next_cycle", bus0.R_Data_A, 32'hDEADBEEF);
    chk("bypass_committed", bus.R_Data_A, 32'hDEADBEEF);

    // Zero register
    bus.R_Addr_A = 5'd0; bus.R_Addr_B = 5'd0;
    drive_write(5'd0, 32'hFFFFFFFF, 4'hF);
    bus.Set_Busy = 1'b1; bus.Busy_Addr = 5'd0;
    #1 chk("zero_reg_write_cycle", bus.R_Data_A, 32'h0);
    tick();
    idle_inputs();
    #1 chk("zero_reg_data", bus.R_Data_B, 32'h0);
    chk("zero_reg_busy", {31'b0, bus.Busy_A}, 32'h0);
    tick();
    chk("zero_reg_busy_later", {31'b0, bus.Busy_B}, 32'h0);

    // Scoreboard
    bus.R_Addr_A = 5'd3; bus.R_Addr_B = 5'd3;
    bus.Set_Busy = 1'b1; bus.Busy_Addr = 5'd3;
    #1 chk("busy_before_set", {31'b0, bus.Busy_A}, 32'h0);
    tick();
    idle_inputs();
    #1 chk("busy_set_a", {31'b0, bus.Busy_A}, 32'h1);
    chk("busy_set_b", {31'b0, bus.Busy_B}, 32'h1);
    drive_write(5'd3, 32'h00000033, 4'hF);
    #1 chk("busy_fwd_clear", {31'b0, bus.Busy_A}, 32'h0);
    tick();
    idle_inputs();
    #1 chk("busy_cleared", {31'b0, bus.Busy_A}, 32'h0);
    bus.Set_Busy = 1'b1; bus.Busy_Addr = 5'd3;
    tick();
    drive_write(5'd3, 32'h00000333, 4'hF);
    #1 chk("set_and_write_same_cycle", {31'b0, bus.Busy_A}, 32'h1);
    tick();
    idle_inputs();
    #1 chk("set_wins_over_write", {31'b0, bus.Busy_B}, 32'h1);
    chk("set_write_data", bus.R_Data_A, 32'h00000333);

    // Fill r1..r31 with i*0x01010101
    for (int i = 1; i < 32; i++) begin
      drive_write(5'(i), 32'(i) * 32'h01010101, 4'hF);
      tick();
    end
    idle_inputs();
    bus.R_Addr_A = 5'd31; bus.R_Addr_B = 5'd16;
    #1 chk("fill_r31", bus.R_Data_A, 32'h1F1F1F1F);
    chk("fill_r16", bus.R_Data_B, 32'h10101010);

    // Clear with a write committing on the request edge
    drive_write(5'd4, 32'h00000044, 4'hF);
    bus.Clear_Req = 1'b1;
    tick();
    idle_inputs();
    bus.R_Addr_A = 5'd4;
    #1 chk("write_with_clear_req", bus.R_Data_A, 32'h00000044);
    chk("dbg_state_clear", {31'b0, dbg_byp}, 32'h1);
    n = 0;
    while (bus.Clear_Busy && n < 100) begin
      drive_write(5'd2, 32'h0000ABCD, 4'hF);
      bus.Set_Busy = 1'b1; bus.Busy_Addr = 5'd9;
      bus.Clear_Req = (n == 10);
      if (n == 5) begin
        bus.R_Addr_A = 5'd2; bus.R_Addr_B = 5'd31;
        #1 chk("partial_clear_r2", bus.R_Data_A, 32'h0);
        chk("partial_clear_r31", bus.R_Data_B, 32'h1F1F1F1F);
      end
      n++;
      tick();
    end
    idle_inputs();
    chk("clear_cycles", 32'(n), 32'd32);
    tick();
    chk("clear_req_dropped", {31'b0, bus.Clear_Busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.R_Addr_A = 5'(i);
      #1 chk($sformatf("cleared_r%0d", i), bus.R_Data_A, 32'h0);
    end
    bus.R_Addr_B = 5'd9;
    #1 chk("busy_set_dropped", {31'b0, bus.Busy_B}, 32'h0);
    bus.R_Addr_B = 5'd3;
    #1 chk("busy_cleared_by_clear", {31'b0, bus.Busy_B}, 32'h0);

    // Reset in the middle of a clear
    tick();
    drive_write(5'd20, 32'h20202020, 4'hF);
    bus.Set_Busy = 1'b1; bus.Busy_Addr = 5'd21;
    tick();
    idle_inputs();
    bus.Clear_Req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    bus.R_Addr_A = 5'd20; bus.R_Addr_B = 5'd21;
    #1 chk("pre_reset_r20", bus.R_Data_A, 32'h20202020);
    chk("pre_reset_busy21", {31'b0, bus.Busy_B}, 32'h1);
    #1 Reset_n = 1'b0;
    #1 chk("midclear_rst_clear_busy", {31'b0, bus.Clear_Busy}, 32'h0);
    chk("midclear_rst_r20", bus.R_Data_A, 32'h0);
    chk("midclear_rst_busy21", {31'b0, bus.Busy_B}, 32'h0);
    #2 Reset_n = 1'b1;
    tick();
    chk("after_rst_idle", {31'b0, bus.Clear_Busy}, 32'h0);
    drive_write(5'd20, 32'h12345678, 4'hF);
    tick();
    idle_inputs();
    #1 chk("after_rst_write", bus.R_Data_A, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
